// File: rtl/evt_packet_arbiter.sv
// Packet-aware N:1 event-stream arbiter: a grant stays locked to one input from the first beat
// until its last beat, with round-robin or fixed-priority selection and an optional length watchdog.
module evt_packet_arbiter #(
  parameter int    DATA_W    = 32,
  parameter int    N_INP     = 4,
  parameter string ARBITER   = "rr",
  parameter int    MAX_BEATS = 0,
  localparam int   IDX_W     = (N_INP > 1) ? $clog2(N_INP) : 1
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic [N_INP*DATA_W-1:0] inp_data_i,
  input  logic [N_INP-1:0]        inp_last_i,
  input  logic [N_INP-1:0]        inp_valid_i,
  output logic [N_INP-1:0]        inp_ready_o,
  output logic [DATA_W-1:0]       oup_data_o,
  output logic                    oup_last_o,
  output logic [IDX_W-1:0]        oup_idx_o,
  output logic                    oup_valid_o,
  input  logic                    oup_ready_i,
  output logic                    locked_o,
  output logic                    err_trunc_o
);

  localparam bit USE_PRIO = (ARBITER == "prio");
  localparam int CNT_W    = (MAX_BEATS > 0) ? $clog2(MAX_BEATS + 1) : 1;

  typedef enum logic {
    IDLE,
    LOCKED
  } state_t;

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   ptr_reg, ptr_next;
  logic [IDX_W-1:0]   grant_reg, grant_next;
  logic [CNT_W-1:0]   cnt_reg, cnt_next;

  logic [DATA_W-1:0]  data_reg;
  logic               last_reg;
  logic [IDX_W-1:0]   idx_reg;
  logic               valid_reg;
  logic               err_reg;

  logic [DATA_W-1:0]  inp_data [N_INP];

  logic [IDX_W-1:0]   rr_sel, prio_sel, win_sel, sel, sel_inc;
  logic               rr_found, prio_found, win_found;
  logic               space, sel_valid, sel_last, xfer, trunc, end_pkt, at_max;
  int                 cand;

  generate
    for (genvar gi = 0; gi < N_INP; gi++) begin : g_unpack
      assign inp_data[gi]    = inp_data_i[gi*DATA_W +: DATA_W];
      assign inp_ready_o[gi] = space & (sel == IDX_W'(gi)) & ((state_reg == LOCKED) | win_found);
    end
  endgenerate

  // Candidate winners for a new packet; only consulted while IDLE.
  always_comb begin
    rr_sel     = '0;
    rr_found   = 1'b0;
    prio_sel   = '0;
    prio_found = 1'b0;
    cand       = 0;
    for (int k = 0; k < N_INP; k++) begin
      cand = int'(ptr_reg) + k;
      if (cand >= N_INP) cand = cand - N_INP;
      if (!rr_found && inp_valid_i[cand]) begin
        rr_found = 1'b1;
        rr_sel   = IDX_W'(cand);
      end
    end
    for (int k = N_INP - 1; k >= 0; k--) begin
      if (inp_valid_i[k]) begin
        prio_found = 1'b1;
        prio_sel   = IDX_W'(k);
      end
    end
  end

  assign win_sel   = USE_PRIO ? prio_sel : rr_sel;
  assign win_found = USE_PRIO ? prio_found : rr_found;

  assign space     = !valid_reg | oup_ready_i;
  assign sel       = (state_reg == LOCKED) ? grant_reg : win_sel;
  assign sel_valid = (state_reg == LOCKED) ? inp_valid_i[grant_reg] : win_found;
  assign sel_last  = inp_last_i[sel];
  assign xfer      = space & sel_valid;
  assign sel_inc   = (sel == IDX_W'(N_INP - 1)) ? '0 : sel + IDX_W'(1);

  // cnt_reg holds beats already passed in this packet (0 while IDLE), so this beat is cnt_reg+1.
  assign at_max    = (MAX_BEATS > 0) && ((int'(cnt_reg) + 1) == MAX_BEATS);
  assign trunc     = xfer & !sel_last & at_max;
  assign end_pkt   = xfer & (sel_last | trunc);

  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    grant_next = grant_reg;
    cnt_next   = cnt_reg;
    if (end_pkt) begin
      state_next = IDLE;
      ptr_next   = USE_PRIO ? '0 : sel_inc;
      cnt_next   = '0;
    end else if (xfer) begin
      state_next = LOCKED;
      grant_next = sel;
      cnt_next   = (cnt_reg == {CNT_W{1'b1}}) ? cnt_reg : cnt_reg + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      ptr_reg   <= '0;
      grant_reg <= '0;
      cnt_reg   <= '0;
      data_reg  <= '0;
      last_reg  <= 1'b0;
      idx_reg   <= '0;
      valid_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      grant_reg <= grant_next;
      cnt_reg   <= cnt_next;
      err_reg   <= trunc;
      if (xfer) begin
        data_reg  <= inp_data[sel];
        last_reg  <= sel_last | trunc;
        idx_reg   <= sel;
        valid_reg <= 1'b1;
      end else if (oup_ready_i) begin
        valid_reg <= 1'b0;
      end
    end
  end

  assign oup_data_o  = data_reg;
  assign oup_last_o  = last_reg;
  assign oup_idx_o   = idx_reg;
  assign oup_valid_o = valid_reg;
  assign locked_o    = (state_reg == LOCKED);
  assign err_trunc_o = err_reg;

endmodule

// File: tb/tb_evt_packet_arbiter.sv
// Scoreboard bench: a round-robin instance with a 4-beat watchdog and a fixed-priority instance.
module tb_evt_packet_arbiter;

  localparam int DW = 32;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [N*DW-1:0] inp_data;
  logic [N-1:0]    inp_last, inp_valid, inp_ready;
  logic [DW-1:0]   oup_data;
  logic            oup_last, oup_valid, oup_ready, locked, err_trunc;
  logic [IW-1:0]   oup_idx;

  logic [N*DW-1:0] p_data;
  logic [N-1:0]    p_last, p_valid, p_ready;
  logic [DW-1:0]   p_oup_data;
  logic            p_oup_last, p_oup_valid, p_oup_ready, p_locked, p_err;
  logic [IW-1:0]   p_oup_idx;

  evt_packet_arbiter #(.DATA_W(DW), .N_INP(N), .ARBITER("rr"), .MAX_BEATS(4)) dut (
    .clk_i(clk), .rst_i(rst), .inp_data_i(inp_data), .inp_last_i(inp_last),
    .inp_valid_i(inp_valid), .inp_ready_o(inp_ready), .oup_data_o(oup_data),
    .oup_last_o(oup_last), .oup_idx_o(oup_idx), .oup_valid_o(oup_valid),
    .oup_ready_i(oup_ready), .locked_o(locked), .err_trunc_o(err_trunc));

  evt_packet_arbiter #(.DATA_W(DW), .N_INP(N), .ARBITER("prio"), .MAX_BEATS(0)) dut_prio (
    .clk_i(clk), .rst_i(rst), .inp_data_i(p_data), .inp_last_i(p_last),
    .inp_valid_i(p_valid), .inp_ready_o(p_ready), .oup_data_o(p_oup_data),
    .oup_last_o(p_oup_last), .oup_idx_o(p_oup_idx), .oup_valid_o(p_oup_valid),
    .oup_ready_i(p_oup_ready), .locked_o(p_locked), .err_trunc_o(p_err));

  typedef struct packed {
    logic [31:0] data;
    logic        last;
    logic [1:0]  idx;
    logic        err;
  } exp_t;

  logic [32:0] src_q [N][$];
  exp_t        exp_q[$];
  exp_t        p_exp_q[$];

  int checks = 0, errors = 0;
  int acc_cnt = 0, err_cnt = 0, in1_viol = 0, onehot_viol = 0, p_viol = 0;
  logic [N-1:0] fire = '0;
  logic [N-1:0] p_pat = '0;
  logic rand_mode = 1'b0, ready_fix = 1'b1, watch_in1 = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] d, input logic l, input int i, input logic e);
    exp_t x;
    x.data = d; x.last = l; x.idx = 2'(i); x.err = e;
    return x;
  endfunction

  task automatic push_src(input int i, input logic [31:0] d, input logic l);
    src_q[i].push_back({l, d});
  endtask

  // One clock: retire last cycle's transfers, present queue heads, sample handshakes before the edge.
  task automatic cycle();
    @(negedge clk);
    for (int i = 0; i < N; i++) if (fire[i]) void'(src_q[i].pop_front());
    for (int i = 0; i < N; i++) begin
      if (src_q[i].size() > 0) begin
        inp_valid[i]           = 1'b1;
        inp_data[i*DW +: DW]   = src_q[i][0][31:0];
        inp_last[i]            = src_q[i][0][32];
      end else begin
        inp_valid[i]           = 1'b0;
        inp_data[i*DW +: DW]   = '0;
        inp_last[i]            = 1'b0;
      end
    end
    oup_ready = rand_mode ? 1'($urandom_range(0, 1)) : ready_fix;
    p_valid   = p_pat;
    #4;
    fire = inp_valid & inp_ready;
    if ($countones(inp_ready) > 1) onehot_viol++;
    if (watch_in1 && src_q[0].size() > 0 && inp_ready[1]) in1_viol++;
    if (err_trunc) err_cnt++;
    if (p_valid[0] && p_ready[3]) p_viol++;
    for (int i = 0; i < N; i++) begin
      if (p_valid[i]) begin
        p_exp_q.push_back(mk(32'hC0 + i, 1'b1, i, 1'b0));
        break;
      end
    end
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while ((exp_q.size() > 0 || src_q[0].size() > 0 || src_q[1].size() > 0 ||
            src_q[2].size() > 0 || src_q[3].size() > 0) && n < budget) begin
      cycle();
      n++;
    end
    cycle();
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: pop and compare whenever either DUT hands a beat to its sink.
  initial begin
    forever begin
      @(negedge clk);
      #4;
      if (!rst && oup_valid && oup_ready) begin
        acc_cnt++;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL out_beat: unexpected beat data=%h idx=%0d", oup_data, oup_idx);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          checks--;
          check("out_beat{data,last,idx,err}", 64'({oup_data, oup_last, oup_idx, err_trunc}), 64'(e));
        end
      end
      if (!rst && p_oup_valid && p_oup_ready) begin
        checks++;
        if (p_exp_q.size() == 0) begin
          errors++;
          $display("FAIL prio_beat: unexpected beat idx=%0d", p_oup_idx);
        end else begin
          exp_t e;
          e = p_exp_q.pop_front();
          checks--;
          check("prio_beat{data,last,idx,err}", 64'({p_oup_data, p_oup_last, p_oup_idx, p_err}), 64'(e));
        end
      end
    end
  end

  initial begin
    int base;
    rst = 1'b1;
    inp_data = '0; inp_last = '0; inp_valid = '0; oup_ready = 1'b1;
    p_data = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
    p_last = '1; p_valid = '0; p_oup_ready = 1'b1;
    repeat (3) cycle();
    check("rst_state{valid,locked,last,err,idx,data}",
          64'({oup_valid, locked, oup_last, err_trunc, oup_idx, oup_data}), 64'd0);
    check("rst_ready", 64'(inp_ready), 64'd0);
    rst = 1'b0;

    // 1: round-robin over four single-beat sources at full rate
    for (int k = 0; k < 2; k++)
      for (int i = 0; i < N; i++) begin
        push_src(i, 32'h1000 * i + k, 1'b1);
        exp_q.push_back(mk(32'h1000 * i + k, 1'b1, i, 1'b0));
      end
    base = acc_cnt;
    repeat (9) cycle();
    @(negedge clk);
    check("rr_full_rate_beats", 64'(acc_cnt - base), 64'd8);
    drain("rr_drain", 50);

    // 2: in0 3-beat packet locks out in1
    watch_in1 = 1'b1;
    push_src(0, 32'hA0, 1'b0); push_src(0, 32'hA1, 1'b0); push_src(0, 32'hA2, 1'b1);
    push_src(1, 32'hB0, 1'b1); push_src(1, 32'hB1, 1'b1);
    exp_q.push_back(mk(32'hA0, 1'b0, 0, 1'b0));
    exp_q.push_back(mk(32'hA1, 1'b0, 0, 1'b0));
    exp_q.push_back(mk(32'hA2, 1'b1, 0, 1'b0));
    exp_q.push_back(mk(32'hB0, 1'b1, 1, 1'b0));
    exp_q.push_back(mk(32'hB1, 1'b1, 1, 1'b0));
    drain("lock_drain", 50);
    watch_in1 = 1'b0;
    check("in1_ready_while_locked", 64'(in1_viol), 64'd0);

    // 3: fixed priority, in0 and in3 streaming; in3 only while in0 idle
    p_pat = 4'b1001; repeat (4) cycle();
    p_pat = 4'b1000; repeat (2) cycle();
    p_pat = 4'b1001; repeat (2) cycle();
    p_pat = 4'b0000; repeat (3) cycle();
    check("prio_drain", 64'(p_exp_q.size()), 64'd0);
    check("prio_in3_ready_blocked", 64'(p_viol), 64'd0);

    // 4: watchdog truncates a 6-beat packet at beat 4; exact 4-beat packet is clean
    err_cnt = 0;
    for (int k = 0; k < 6; k++) push_src(2, 32'hC00 + k, (k == 5));
    for (int k = 0; k < 4; k++) push_src(2, 32'hD00 + k, (k == 3));
    for (int k = 0; k < 6; k++)
      exp_q.push_back(mk(32'hC00 + k, (k == 3) || (k == 5), 2, (k == 3)));
    for (int k = 0; k < 4; k++)
      exp_q.push_back(mk(32'hD00 + k, (k == 3), 2, 1'b0));
    drain("wdog_drain", 60);
    check("wdog_err_pulses", 64'(err_cnt), 64'd1);

    // 5: random backpressure across three locked packets
    rand_mode = 1'b1;
    push_src(3, 32'hE30, 1'b0); push_src(3, 32'hE31, 1'b1);
    for (int k = 0; k < 4; k++) push_src(0, 32'hE00 + k, (k == 3));
    for (int k = 0; k < 3; k++) push_src(1, 32'hE10 + k, (k == 2));
    exp_q.push_back(mk(32'hE30, 1'b0, 3, 1'b0));
    exp_q.push_back(mk(32'hE31, 1'b1, 3, 1'b0));
    for (int k = 0; k < 4; k++) exp_q.push_back(mk(32'hE00 + k, (k == 3), 0, 1'b0));
    for (int k = 0; k < 3; k++) exp_q.push_back(mk(32'hE10 + k, (k == 2), 1, 1'b0));
    drain("stall_drain", 300);
    rand_mode = 1'b0;

    // 6: reset mid-packet with a beat held in the output register
    ready_fix = 1'b0;
    push_src(0, 32'hF0, 1'b0); push_src(0, 32'hF1, 1'b0); push_src(0, 32'hF2, 1'b1);
    cycle();
    cycle();
    check("pre_rst_locked_valid", 64'({locked, oup_valid}), 64'b11);
    rst = 1'b1;
    cycle();
    check("post_rst{valid,locked,err,idx}", 64'({oup_valid, locked, err_trunc, oup_idx}), 64'd0);
    rst = 1'b0;
    ready_fix = 1'b1;
    push_src(3, 32'hF3, 1'b1);
    exp_q.push_back(mk(32'hF1, 1'b0, 0, 1'b0));
    exp_q.push_back(mk(32'hF2, 1'b1, 0, 1'b0));
    exp_q.push_back(mk(32'hF3, 1'b1, 3, 1'b0));
    drain("post_rst_drain", 50);

    check("ready_onehot", 64'(onehot_viol), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
